// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read-side controller.
//   D_WIDTH    : default stream / FIFO data width
//   W_WIDTH    : width of the 2-entry buffer occupancy count (0..2)
//   rd_state_e : read controller FSM states
package fifo_pkg;

    localparam int D_WIDTH = 8;
    localparam int W_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        ERR    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order buffer between the FIFO read port and the
// output stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   head       : current head entry (stable until popped)
//   occ        : number of valid entries, 0..2
// The caller guarantees push never happens with occ==2 unless pop is also set.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int D_W = D_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [D_W-1:0]     din,
    input  logic               pop,
    output logic [D_W-1:0]     head,
    output logic [W_WIDTH-1:0] occ
);

    logic [D_W-1:0]     mem_q [2];
    logic [D_W-1:0]     mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [W_WIDTH-1:0] occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        occ_d = occ_q + W_WIDTH'(push) - W_WIDTH'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: pops words out of a synchronous FIFO (1-cycle read latency)
// and presents them as a valid/ready stream through a 2-entry buffer.
//   clk, rst_n       : clock, asynchronous active-low reset
//   en               : read enable
//   pop              : pop request to the FIFO (combinational)
//   data_out         : FIFO read data, valid the cycle after pop
//   empty            : FIFO empty
//   pop_err_on_empty : FIFO error pulse for the previous pop
//   m_valid/m_data/m_ready : output stream
//   err_clr, err     : sticky error clear / flag
//   busy             : not IDLE or buffer holds data
//   pop_cnt          : number of words captured (wraps)
//
// state  | meaning
// IDLE   | waiting for en
// ACTIVE | issuing pops while credit allows
// DRAIN  | en dropped, waiting for the last in-flight word
// ERR    | FIFO reported a bad pop; no pops until err_clr
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int D_W   = D_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pop,
    input  logic [D_W-1:0]   data_out,
    input  logic             empty,
    input  logic             pop_err_on_empty,
    output logic             m_valid,
    output logic [D_W-1:0]   m_data,
    input  logic             m_ready,
    input  logic             err_clr,
    output logic             err,
    output logic             busy,
    output logic [CNT_W-1:0] pop_cnt
);

    rd_state_e          state_q, state_d;
    logic               inflight_q, inflight_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic [W_WIDTH-1:0] occ;
    logic               xfer;
    logic               capture;
    logic               err_cap;
    logic [2:0]         credit_used;

    assign m_valid = (occ != '0);
    assign xfer    = m_valid && m_ready;
    assign capture = inflight_q && !pop_err_on_empty;
    assign err_cap = inflight_q && pop_err_on_empty;

    // Entries committed after this edge if nothing new is popped: words
    // already buffered plus the one in flight, minus one leaving now.
    // Popping only while this is below 2 keeps the buffer from overflowing.
    assign credit_used = 3'(occ) + 3'(inflight_q) - 3'(xfer);
    assign pop = (state_q == ACTIVE) && en && !empty && (credit_used < 3'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ACTIVE;
            ACTIVE:  if (!en) state_d = inflight_q ? DRAIN : IDLE;
            DRAIN:   if (!inflight_q) state_d = IDLE;
            ERR:     if (err_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An error capture overrides everything, including err_clr.
        if (err_cap) state_d = ERR;

        inflight_d = pop;
        err_d      = (state_d == ERR);
        pop_cnt_d  = pop_cnt_q + CNT_W'(capture);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            pop_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    fifo_rd_skid #(
        .D_W (D_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .din   (data_out),
        .pop   (xfer),
        .head  (m_data),
        .occ   (occ)
    );

    assign err     = err_q;
    assign busy    = (state_q != IDLE) || m_valid;
    assign pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a small FIFO source model feeds the DUT,
// a monitor logs pops and stream transfers, and one task per scenario checks
// hand-computed expectations. A second instance with CNT_W=4 covers wrap.
module tb_fifo_rd_ctrl;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pop;
    logic [7:0]  data_out = 8'h00;
    logic        empty;
    logic        pop_err_on_empty = 1'b0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        err;
    logic        busy;
    logic [15:0] pop_cnt;

    logic        w_en = 1'b0;
    logic        w_pop;
    logic [7:0]  w_data_out = 8'h00;
    logic        w_empty;
    logic        w_perr = 1'b0;
    logic        w_m_valid;
    logic [7:0]  w_m_data;
    logic        w_m_ready = 1'b1;
    logic        w_err_clr = 1'b0;
    logic        w_err;
    logic        w_busy;
    logic [3:0]  w_pop_cnt;

    int checks = 0;
    int errors = 0;

    // FIFO source model
    logic [7:0] src_mem [64];
    int src_wr = 0;
    int src_rd = 0;
    int bad_pop = 0;
    assign empty = (src_wr == src_rd);

    // Monitor state
    int cyc = 0;
    int n_pops = 0;
    int first_pop_cyc = -1;
    logic [7:0] rx_data [$];
    int rx_cyc [$];

    int w_pops = 0;
    int w_rx = 0;
    assign w_empty = (w_pops >= 17);

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.D_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pop(pop), .data_out(data_out),
        .empty(empty), .pop_err_on_empty(pop_err_on_empty), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .err_clr(err_clr), .err(err),
        .busy(busy), .pop_cnt(pop_cnt)
    );

    fifo_rd_ctrl #(.D_W(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(w_en), .pop(w_pop), .data_out(w_data_out),
        .empty(w_empty), .pop_err_on_empty(w_perr), .m_valid(w_m_valid),
        .m_data(w_m_data), .m_ready(w_m_ready), .err_clr(w_err_clr), .err(w_err),
        .busy(w_busy), .pop_cnt(w_pop_cnt)
    );

    always @(posedge clk) begin
        if (pop) begin
            n_pops = n_pops + 1;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            data_out <= src_mem[src_rd];
            src_rd = src_rd + 1;
            pop_err_on_empty <= (n_pops == bad_pop);
        end else begin
            pop_err_on_empty <= 1'b0;
        end
        if (m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_cyc.push_back(cyc);
        end
        if (w_pop) begin
            w_pops = w_pops + 1;
            w_data_out <= 8'(w_pops);
        end
        if (w_m_valid && w_m_ready) w_rx = w_rx + 1;
        cyc = cyc + 1;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_src(input logic [7:0] d);
        src_mem[src_wr] = d;
        src_wr = src_wr + 1;
    endtask

    task automatic clear_logs();
        n_pops = 0;
        first_pop_cyc = -1;
        rx_data.delete();
        rx_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(2);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", pop); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (pop_cnt !== 16'd0) begin errors++; $display("FAIL reset_pop_cnt: got %0d expected 0", pop_cnt); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
        rst_n = 1'b1;
        cycles(2);
        checks++; if (n_pops !== 0) begin errors++; $display("FAIL reset_no_pop_without_en: got %0d expected 0", n_pops); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        logic [7:0] got;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) push_src(exp[i]);
        clear_logs();
        en = 1'b1; m_ready = 1'b1;
        cycles(8);
        checks++; if (n_pops !== 3) begin errors++; $display("FAIL basic_pops: got %0d expected 3", n_pops); end
        checks++; if (rx_data.size() !== 3) begin errors++; $display("FAIL basic_rx_count: got %0d expected 3", rx_data.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rx_data.size()) ? rx_data[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL basic_data%0d: got %h expected %h", i, got, exp[i]); end
        end
        if (rx_cyc.size() == 3) begin
            checks++; if (rx_cyc[0] !== first_pop_cyc + 2) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", rx_cyc[0], first_pop_cyc + 2); end
            checks++; if (rx_cyc[2] !== rx_cyc[0] + 2) begin errors++; $display("FAIL basic_throughput: got cycle %0d expected %0d", rx_cyc[2], rx_cyc[0] + 2); end
        end
        checks++; if (pop_cnt !== 16'd3) begin errors++; $display("FAIL basic_pop_cnt: got %0d expected 3", pop_cnt); end
        en = 1'b0;
        cycles(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        logic [7:0] got;
        exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'hA4;
        for (int i = 0; i < 4; i++) push_src(exp[i]);
        clear_logs();
        m_ready = 1'b0; en = 1'b1;
        cycles(5);
        checks++; if (n_pops !== 2) begin errors++; $display("FAIL bp_pops: got %0d expected 2", n_pops); end
        checks++; if (dut.occ !== 2'd2) begin errors++; $display("FAIL bp_occ: got %0d expected 2", dut.occ); end
        checks++; if (m_data !== 8'hA1) begin errors++; $display("FAIL bp_head: got %h expected a1", m_data); end
        cycles(3);
        checks++; if (m_data !== 8'hA1 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_stable: got %h/%b expected a1/1", m_data, m_valid); end
        checks++; if (n_pops !== 2) begin errors++; $display("FAIL bp_pops_held: got %0d expected 2", n_pops); end
        m_ready = 1'b1;
        cycles(10);
        checks++; if (rx_data.size() !== 4) begin errors++; $display("FAIL bp_rx_count: got %0d expected 4", rx_data.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_data.size()) ? rx_data[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++; if (pop_cnt !== 16'd7) begin errors++; $display("FAIL bp_pop_cnt: got %0d expected 7", pop_cnt); end
        en = 1'b0;
        cycles(2);
    endtask

    task automatic test_error();
        push_src(8'hB1); push_src(8'hB2);
        clear_logs();
        bad_pop = 2;
        m_ready = 1'b1; en = 1'b1;
        cycles(6);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", err); end
        checks++; if (dut.state_q !== ERR) begin errors++; $display("FAIL err_state: got %0d expected %0d", dut.state_q, ERR); end
        checks++; if (rx_data.size() !== 1) begin errors++; $display("FAIL err_rx_count: got %0d expected 1", rx_data.size()); end
        if (rx_data.size() > 0) begin
            checks++; if (rx_data[0] !== 8'hB1) begin errors++; $display("FAIL err_first_word: got %h expected b1", rx_data[0]); end
        end
        checks++; if (pop_cnt !== 16'd8) begin errors++; $display("FAIL err_pop_cnt: got %0d expected 8", pop_cnt); end
        bad_pop = 0;
        push_src(8'hC1); push_src(8'hC2);
        clear_logs();
        cycles(4);
        checks++; if (n_pops !== 0) begin errors++; $display("FAIL err_no_pops: got %0d expected 0", n_pops); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_busy: got %b expected 1", busy); end
        en = 1'b0; err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_flag: got %b expected 0", err); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL err_clear_state: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_drain();
        push_src(8'hC3);
        clear_logs();
        m_ready = 1'b1; en = 1'b1;
        cycles(2);
        en = 1'b0;
        #1;
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL drain_en_blocks_pop: got %b expected 0", pop); end
        cycles(1);
        checks++; if (dut.state_q !== DRAIN) begin errors++; $display("FAIL drain_state: got %0d expected %0d", dut.state_q, DRAIN); end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hC1) begin errors++; $display("FAIL drain_word: got %b/%h expected 1/c1", m_valid, m_data); end
        cycles(1);
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL drain_to_idle: got %0d expected %0d", dut.state_q, IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy: got %b expected 0", busy); end
        checks++; if (n_pops !== 1 || rx_data.size() !== 1) begin errors++; $display("FAIL drain_counts: got pops %0d rx %0d expected 1/1", n_pops, rx_data.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        push_src(8'hD1); push_src(8'hD2);
        clear_logs();
        m_ready = 1'b0; en = 1'b1;
        cycles(5);
        checks++; if (dut.occ !== 2'd2) begin errors++; $display("FAIL rst_pre_occ: got %0d expected 2", dut.occ); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_async_m_valid: got %b expected 0", m_valid); end
        checks++; if (pop_cnt !== 16'd0) begin errors++; $display("FAIL rst_async_pop_cnt: got %0d expected 0", pop_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rst_async_pop: got %b expected 0", pop); end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        m_ready = 1'b1;
        cycles(4);
        checks++; if (n_pops !== 0) begin errors++; $display("FAIL rst_wait_en: got %0d pops expected 0", n_pops); end
        en = 1'b1;
        cycles(8);
        checks++; if (n_pops !== 2) begin errors++; $display("FAIL rst_resume_pops: got %0d expected 2", n_pops); end
        got = (rx_data.size() > 0) ? rx_data[0] : 8'hxx;
        checks++; if (got !== 8'hD1) begin errors++; $display("FAIL rst_resume_data: got %h expected d1", got); end
        checks++; if (pop_cnt !== 16'd2) begin errors++; $display("FAIL rst_resume_pop_cnt: got %0d expected 2", pop_cnt); end
        en = 1'b0;
        cycles(2);
    endtask

    task automatic test_wrap();
        w_en = 1'b1;
        cycles(30);
        checks++; if (w_pops !== 17) begin errors++; $display("FAIL wrap_pops: got %0d expected 17", w_pops); end
        checks++; if (w_rx !== 17) begin errors++; $display("FAIL wrap_rx: got %0d expected 17", w_rx); end
        checks++; if (w_pop_cnt !== 4'd1) begin errors++; $display("FAIL wrap_pop_cnt: got %0d expected 1", w_pop_cnt); end
        w_en = 1'b0;
        cycles(2);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_error();
        test_drain();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- D_W, fifo_pkg::D_WIDTH, data width.
- CNT_W, 16, pop counter width.
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- en, in, 1, read enable.
- pop, out, 1, pop request to FIFO.
- data_out, in, D_W, FIFO read data, valid the cycle after pop is sampled.
- empty, in, 1, FIFO empty.
- pop_err_on_empty, in, 1, FIFO error pulse, arrives the cycle after a pop.
- m_valid, out, 1, stream valid.
- m_data, out, D_W, stream data.
- m_ready, in, 1, stream ready.
- err_clr, in, 1, clears sticky error.
- err, out, 1, sticky error flag.
- busy, out, 1, state != IDLE or buffer occupied.
- pop_cnt, out, CNT_W, count of words captured.

Function
REQ-003 Buffer: 2 entries; occ SHALL be 0..2; inflight SHALL be a 1-bit flag, set in the cycle after pop=1.
REQ-004 pop SHALL be combinational: state==ACTIVE and en and !empty and (occ + inflight - (m_valid&&m_ready)) < 2.
REQ-005 At a rising edge with inflight=1 and pop_err_on_empty=0, data_out SHALL be written to the buffer tail and pop_cnt incremented; pop_cnt wraps 2^CNT_W-1 -> 0.
REQ-006 inflight=1 with pop_err_on_empty=1 SHALL discard data_out; pop_cnt SHALL be unchanged.
REQ-007 m_valid SHALL be occ!=0; m_data SHALL be the head entry and SHALL hold stable while m_valid && !m_ready.
REQ-008 Transfer SHALL occur on m_valid && m_ready. Simultaneous capture and transfer SHALL leave occ unchanged, preserving order.
REQ-009 Latency: pop in cycle N SHALL give m_valid in cycle N+2.
REQ-010 Throughput: with m_ready=1 held and the FIFO non-empty, SHALL sustain 1 word/cycle.
REQ-011 The credit rule SHALL guarantee occ never exceeds 2; no capture is ever dropped for lack of space.
REQ-012 FSM states: IDLE, ACTIVE, DRAIN, ERR.
REQ-013 Transitions:
- IDLE -> ACTIVE on en=1.
- ACTIVE -> DRAIN on en=0 with inflight=1.
- ACTIVE -> IDLE on en=0 with inflight=0.
- DRAIN -> IDLE once inflight=0.
- Any state -> ERR on an error capture per REQ-006.
- ERR -> IDLE on err_clr=1.
REQ-014 In DRAIN and ERR, buffered words SHALL still be presented on the stream; no new pops are issued.
REQ-015 err SHALL be 1 exactly while state==ERR. If err_clr and an error capture occur in the same cycle, the error SHALL win and the state remains ERR.
REQ-016 en=0 SHALL block pop in the same cycle.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- state=IDLE, occ=0, inflight=0.
- err=0, busy=0, pop_cnt=0.
- m_valid=0, m_data=0, pop=0.
REQ-018 Reset mid-operation SHALL discard buffered and in-flight words; after release, the block waits for en.

Structure
REQ-019 fifo_pkg SHALL hold D_WIDTH, W_WIDTH and typedef enum rd_state_e {IDLE, ACTIVE, DRAIN, ERR}.
REQ-020 The 2-entry buffer SHALL be a sub-module fifo_rd_skid (push, data in, pop, head, occ). The FSM and credit logic remain in fifo_rd_ctrl.

Verification
REQ-021 Bench SHALL cover these directed scenarios (stimulus -> required response):
- Basic read: FIFO holds 0x11,0x22,0x33; en=1, m_ready=1 -> pop for 3 cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first pop; pop_cnt=3.
- Backpressure: m_ready=0 for 5 cycles, FIFO holds 4 words -> exactly 2 pops, then occ=2 and m_data stable. Releasing m_ready delivers all 4 words in order with no loss.
- Error: pop_err_on_empty=1 after the 2nd pop -> 2nd word discarded, err=1, pops stop, the 1st word is still delivered. err_clr -> IDLE, err=0.
- Drain: en=0 while inflight=1 -> state DRAIN, no further pop, the in-flight word is delivered, then IDLE and busy=0.
- Reset: rst_n=0 with occ=2 -> m_valid=0 immediately (asynchronous), pop_cnt=0; after release, no pop until en=1.
- Wrap: CNT_W=4, 17 words read -> pop_cnt=1.
